aes_xram_arb: RTL and testbench

- Two-master, one-slave arbiter for the XRAM port, sitting directly downstream of the AES accelerator's XRAM master interface.
- Masters are the oc8051 XRAM port (cpu_*) and the AES unit (aes_*); the slave is the shared XRAM.
- Serialises byte transactions with round-robin fairness.
- Filters CPU accesses that fall in the AES MMIO window so they never reach XRAM.

---
 rtl/aes_xram_arb.sv | 123 ++++++++++++
 tb/tb_aes_xram_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_xram_arb.sv
// Two-master (oc8051 CPU, AES unit) round-robin arbiter onto the shared XRAM port; CPU hits in the AES MMIO window are filtered.
// Optional ack timeout with sticky arb_err is enabled by defining AES_XRAM_ARB_TIMEOUT_EN.
module aes_xram_arb #(
  parameter logic [15:0] MMIO_BASE = 16'hff00,
  parameter logic [15:0] MMIO_END  = 16'hff30
`ifdef AES_XRAM_ARB_TIMEOUT_EN
  , parameter logic [7:0] TIMEOUT  = 8'd64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_wr,
  input  logic        cpu_stb,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_ack,
  input  logic [15:0] aes_addr,
  input  logic [7:0]  aes_data_in,
  input  logic        aes_wr,
  input  logic        aes_stb,
  output logic [7:0]  aes_data_out,
  output logic        aes_ack,
  output logic [15:0] xram_addr,
  output logic [7:0]  xram_data_out,
  output logic        xram_wr,
  output logic        xram_stb,
  input  logic [7:0]  xram_data_in,
  input  logic        xram_ack,
  output logic        arb_err
);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_AES} state_t;

  state_t state;
  logic   last_gnt;
  logic   in_win;
  logic   cpu_req;
  logic   aes_req;
  logic   gnt_stb;
  logic   tmo;

  assign in_win  = (cpu_addr >= MMIO_BASE) && (cpu_addr < MMIO_END);
  assign cpu_req = cpu_stb && !in_win;
  assign aes_req = aes_stb;
  assign gnt_stb = (state == GNT_AES) ? aes_stb : cpu_stb;

`ifdef AES_XRAM_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign tmo = (state != IDLE) && gnt_stb && !xram_ack && (wait_cnt == TIMEOUT - 8'd1);

  // Wait counter restarts on every grant; error flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
      arb_err  <= 1'b0;
    end else begin
      wait_cnt <= (state == IDLE) ? 8'd0 : wait_cnt + 8'd1;
      if (tmo) arb_err <= 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign arb_err = 1'b0;
`endif

  // Grant FSM: one byte per grant, always back through IDLE to re-arbitrate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req && (!aes_req || last_gnt)) state <= GNT_CPU;
          else if (aes_req)                      state <= GNT_AES;
        end
        GNT_CPU, GNT_AES: begin
          if (xram_ack || tmo) begin
            state    <= IDLE;
            last_gnt <= (state == GNT_AES);
          end else if (!gnt_stb) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath mux; the non-granted master sees zeros.
  always_comb begin
    xram_addr     = 16'h0000;
    xram_data_out = 8'h00;
    xram_wr       = 1'b0;
    xram_stb      = 1'b0;
    cpu_ack       = 1'b0;
    cpu_data_out  = 8'h00;
    aes_ack       = 1'b0;
    aes_data_out  = 8'h00;
    case (state)
      GNT_CPU: begin
        xram_addr     = cpu_addr;
        xram_data_out = cpu_data_in;
        xram_wr       = cpu_wr;
        xram_stb      = cpu_stb && !tmo;
        cpu_ack       = xram_ack || tmo;
        cpu_data_out  = tmo ? 8'hff : xram_data_in;
      end
      GNT_AES: begin
        xram_addr     = aes_addr;
        xram_data_out = aes_data_in;
        xram_wr       = aes_wr;
        xram_stb      = aes_stb && !tmo;
        aes_ack       = xram_ack || tmo;
        aes_data_out  = tmo ? 8'hff : xram_data_in;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_xram_arb.sv
// Directed bench for aes_xram_arb: expected grants are queued as stimulus is driven and popped when the DUT grants.
module tb_aes_xram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_wr;
  logic        cpu_stb;
  logic [7:0]  cpu_data_out;
  logic        cpu_ack;
  logic [15:0] aes_addr;
  logic [7:0]  aes_data_in;
  logic        aes_wr;
  logic        aes_stb;
  logic [7:0]  aes_data_out;
  logic        aes_ack;
  logic [15:0] xram_addr;
  logic [7:0]  xram_data_out;
  logic        xram_wr;
  logic        xram_stb;
  logic [7:0]  xram_data_in;
  logic        xram_ack;
  logic        arb_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        aes;
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];

  aes_xram_arb dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_wr(cpu_wr), .cpu_stb(cpu_stb),
    .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack),
    .aes_addr(aes_addr), .aes_data_in(aes_data_in), .aes_wr(aes_wr), .aes_stb(aes_stb),
    .aes_data_out(aes_data_out), .aes_ack(aes_ack),
    .xram_addr(xram_addr), .xram_data_out(xram_data_out), .xram_wr(xram_wr), .xram_stb(xram_stb),
    .xram_data_in(xram_data_in), .xram_ack(xram_ack), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic aes, input logic [15:0] addr, input logic wr, input logic [7:0] data);
    exp_t e;
    e.aes = aes; e.addr = addr; e.wr = wr; e.data = data;
    sb.push_back(e);
  endtask

  // Compare the current grant against the oldest expected transaction.
  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed grant with empty scoreboard, expected none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_stb"},  32'(xram_stb), 32'(1));
      chk({tag, "_addr"}, 32'(xram_addr), 32'(e.addr));
      chk({tag, "_wr"},   32'(xram_wr), 32'(e.wr));
      if (e.wr) chk({tag, "_data"}, 32'(xram_data_out), 32'(e.data));
      if (xram_ack) begin
        chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'(!e.aes));
        chk({tag, "_aes_ack"}, 32'(aes_ack), 32'(e.aes));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic model_last;
  logic win_aes;

  initial begin
    rst = 1'b1;
    cpu_addr = '0; cpu_data_in = '0; cpu_wr = 1'b0; cpu_stb = 1'b0;
    aes_addr = '0; aes_data_in = '0; aes_wr = 1'b0; aes_stb = 1'b0;
    xram_data_in = '0; xram_ack = 1'b0;
    #1;
    chk("rst_outs", {xram_addr, xram_data_out, xram_wr, xram_stb, cpu_ack, aes_ack}, 32'(0));
    chk("rst_data", {cpu_data_out, aes_data_out}, 32'(0));
    chk("rst_err", 32'(arb_err), 32'(0));
    step();
    rst = 1'b0;

    // CPU write 0010/5a, ack in the second granted cycle
    step();
    cpu_addr = 16'h0010; cpu_data_in = 8'h5a; cpu_wr = 1'b1; cpu_stb = 1'b1;
    push(1'b0, 16'h0010, 1'b1, 8'h5a);
    #1 chk("t1_idle_stb", 32'(xram_stb), 32'(0));
    step();
    pop_chk("t1_grant");
    chk("t1_noack", 32'(cpu_ack), 32'(0));
    step();
    xram_ack = 1'b1;
    #1;
    chk("t1_cpu_ack", 32'(cpu_ack), 32'(1));
    chk("t1_aes_ack", 32'(aes_ack), 32'(0));
    step();
    cpu_stb = 1'b0; xram_ack = 1'b0;
    #1;
    chk("t1_back_idle", 32'(xram_stb), 32'(0));
    chk("t1_ack_drop", 32'(cpu_ack), 32'(0));

    // CPU read in the MMIO window is never forwarded
    step();
    cpu_addr = 16'hff01; cpu_wr = 1'b0; cpu_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_mmio_stb", 32'(xram_stb), 32'(0));
      chk("t2_mmio_ack", 32'(cpu_ack), 32'(0));
    end
    // First address past the window is forwarded, then abandoned
    cpu_addr = 16'hff30;
    push(1'b0, 16'hff30, 1'b0, 8'h00);
    step();
    pop_chk("t2_win_end");
    cpu_stb = 1'b0;
    #1 chk("t2_abandon_stb", 32'(xram_stb), 32'(0));
    step();
    chk("t2_abandon_idle", 32'(xram_stb), 32'(0));
    chk("t2_abandon_ack", 32'(cpu_ack), 32'(0));

    // Both request after reset, xram_ack constant: strict alternation starting with AES
    do_reset();
    cpu_addr = 16'h0040; cpu_wr = 1'b1; cpu_data_in = 8'h11; cpu_stb = 1'b1;
    aes_addr = 16'h0300; aes_wr = 1'b1; aes_data_in = 8'h22; aes_stb = 1'b1;
    xram_ack = 1'b1;
    model_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      win_aes = !model_last;
      if (win_aes) push(1'b1, 16'h0300, 1'b1, 8'h22);
      else         push(1'b0, 16'h0040, 1'b1, 8'h11);
      model_last = win_aes;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      pop_chk($sformatf("t3_rr%0d", i));
      step();
      chk($sformatf("t3_gap%0d", i), 32'(xram_stb), 32'(0));
    end
    cpu_stb = 1'b0; aes_stb = 1'b0; xram_ack = 1'b0;
    step();

    // AES read returns XRAM data only to AES
    aes_addr = 16'h0200; aes_wr = 1'b0; aes_stb = 1'b1;
    push(1'b1, 16'h0200, 1'b0, 8'h00);
    step();
    xram_data_in = 8'hc3; xram_ack = 1'b1;
    #1;
    pop_chk("t4_read");
    chk("t4_aes_data", 32'(aes_data_out), 32'(8'hc3));
    chk("t4_cpu_data", 32'(cpu_data_out), 32'(0));
    step();
    aes_stb = 1'b0; xram_ack = 1'b0; xram_data_in = 8'h00;
    step();

    // Async reset in the middle of an AES grant
    aes_addr = 16'h0300; aes_wr = 1'b1; aes_stb = 1'b1;
    push(1'b1, 16'h0300, 1'b1, 8'h22);
    step();
    pop_chk("t5_aes_gnt");
    cpu_addr = 16'h0050; cpu_wr = 1'b0; cpu_stb = 1'b1;
    #2 rst = 1'b1; xram_ack = 1'b1;
    #1;
    chk("t5_rst_outs", {xram_addr, xram_data_out, xram_wr, xram_stb, cpu_ack, aes_ack}, 32'(0));
    chk("t5_rst_data", {cpu_data_out, aes_data_out}, 32'(0));
    aes_stb = 1'b0; xram_ack = 1'b0;
    step();
    rst = 1'b0;
    push(1'b0, 16'h0050, 1'b0, 8'h00);
    step();
    pop_chk("t5_cpu_after_rst");
    chk("t5_err", 32'(arb_err), 32'(0));
    cpu_stb = 1'b0;
    step();

`ifdef AES_XRAM_ARB_TIMEOUT_EN
    // Timeout: ack with 8'hff on the 64th granted cycle, sticky arb_err
    cpu_addr = 16'h0060; cpu_wr = 1'b0; cpu_stb = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k < 64) begin
        chk($sformatf("t6_wait%0d", k), 32'(cpu_ack), 32'(0));
      end else begin
        chk("t6_tmo_ack", 32'(cpu_ack), 32'(1));
        chk("t6_tmo_data", 32'(cpu_data_out), 32'(8'hff));
        chk("t6_tmo_stb", 32'(xram_stb), 32'(0));
      end
    end
    cpu_stb = 1'b0;
    step();
    chk("t6_err_set", 32'(arb_err), 32'(1));
    step();
    step();
    chk("t6_err_sticky", 32'(arb_err), 32'(1));
    do_reset();
    #1 chk("t6_err_clr", 32'(arb_err), 32'(0));
`endif

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
